// File: rtl/otter_pkg.sv
// Shared encodings for the OTTER front end: PC select codes and fetch FSM states.
package otter_pkg;

    localparam logic [2:0] PC_SEL_SEQ    = 3'd0;
    localparam logic [2:0] PC_SEL_JALR   = 3'd1;
    localparam logic [2:0] PC_SEL_BRANCH = 3'd2;
    localparam logic [2:0] PC_SEL_JAL    = 3'd3;
    localparam logic [2:0] PC_SEL_MTVEC  = 3'd4;
    localparam logic [2:0] PC_SEL_MEPC   = 3'd5;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t S_RESET = 3'd0;
    localparam fetch_state_t S_REQ   = 3'd1;
    localparam fetch_state_t S_WAIT  = 3'd2;
    localparam fetch_state_t S_HOLD  = 3'd3;
    localparam fetch_state_t S_KILL  = 3'd4;

endpackage

// File: rtl/otter_pc_target_mux.sv
// Redirect target selection: jalr bit0 clear, alignment check on jump/branch targets.
module otter_pc_target_mux
    import otter_pkg::*;
(
    input  logic        ex_valid,
    input  logic [2:0]  ex_pc_sel,
    input  logic [31:0] jal_addr,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jalr_addr,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        redirect,
    output logic [31:0] target,
    output logic        misaligned,
    output logic [31:0] next_pc
);

    logic checked;

    always_comb begin
        redirect = 1'b0;
        checked  = 1'b0;
        target   = mtvec;
        if (ex_valid) begin
            case (ex_pc_sel)
                PC_SEL_JALR: begin
                    redirect = 1'b1;
                    checked  = 1'b1;
                    target   = {jalr_addr[31:1], 1'b0};
                end
                PC_SEL_BRANCH: begin
                    redirect = 1'b1;
                    checked  = 1'b1;
                    target   = branch_addr;
                end
                PC_SEL_JAL: begin
                    redirect = 1'b1;
                    checked  = 1'b1;
                    target   = jal_addr;
                end
                PC_SEL_MTVEC: begin
                    redirect = 1'b1;
                    target   = mtvec;
                end
                PC_SEL_MEPC: begin
                    redirect = 1'b1;
                    target   = mepc;
                end
                default: ;
            endcase
        end
        // Trap vectors are trusted; only computed control-flow targets are checked.
        misaligned = checked && (target[1:0] != 2'b00);
        next_pc    = misaligned ? mtvec : target;
    end

endmodule

// File: rtl/otter_pc_sequencer.sv
// OTTER fetch PC sequencer: single-outstanding imem handshake, redirect/kill, decode hand-off.
module otter_pc_sequencer
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [2:0]  ex_pc_sel,
    input  logic [31:0] jal_addr,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jalr_addr,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_trap,
    output logic [31:0] misalign_addr,
    output logic [31:0] pc
);

    fetch_state_t state;
    logic [31:0]  issued_pc;
    logic         redirect;
    logic         misaligned;
    logic [31:0]  target;
    logic [31:0]  next_pc;

    otter_pc_target_mux u_target_mux (
        .ex_valid    (ex_valid),
        .ex_pc_sel   (ex_pc_sel),
        .jal_addr    (jal_addr),
        .branch_addr (branch_addr),
        .jalr_addr   (jalr_addr),
        .mtvec       (mtvec),
        .mepc        (mepc),
        .redirect    (redirect),
        .target      (target),
        .misaligned  (misaligned),
        .next_pc     (next_pc)
    );

    assign imem_addr      = pc;
    assign imem_req_valid = (state == S_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RESET;
            pc            <= RESET_VEC;
            issued_pc     <= RESET_VEC;
            if_valid      <= 1'b0;
            if_instr      <= '0;
            if_pc         <= '0;
            misalign_trap <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_trap <= 1'b0;
            if (redirect) begin
                pc <= next_pc;
                if (misaligned) begin
                    misalign_trap <= 1'b1;
                    misalign_addr <= target;
                end
            end

            case (state)
                S_RESET: state <= S_REQ;
                S_REQ: begin
                    // A request accepted alongside a redirect fetches a dead address.
                    if (redirect) begin
                        if (imem_req_ready) state <= S_KILL;
                    end else if (imem_req_ready) begin
                        issued_pc <= pc;
                        pc        <= pc + 32'd4;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        state <= imem_rsp_valid ? S_REQ : S_KILL;
                    end else if (imem_rsp_valid) begin
                        if_instr <= imem_rsp_data;
                        if_pc    <= issued_pc;
                        if_valid <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect || if_ready) begin
                        if_valid <= 1'b0;
                        state    <= S_REQ;
                    end
                end
                S_KILL: begin
                    if (imem_rsp_valid) state <= S_REQ;
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: doc/otter_pc_sequencer.md
Name: otter_pc_sequencer

Overview:
- Program-counter sequencer and fetch controller for the OTTER front end.
- Holds the architectural fetch PC and consumes the targets from the branch/jump address generator (jal, branch, jalr) plus trap vectors (mtvec, mepc).
- Selects the next PC on execute-stage redirects and runs a single-outstanding request/response handshake to instruction memory.
- Delivers a fetched instruction/PC pair to decode with valid/ready, and kills in-flight fetches on redirect.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents a resolved control-flow decision this cycle
- ex_pc_sel  in  3  0=seq, 1=jalr, 2=branch, 3=jal, 4=mtvec, 5=mepc, 6/7 reserved (=seq)
- jal_addr  in  32  jal target
- branch_addr  in  32  taken-branch target
- jalr_addr  in  32  jalr target (rs1+imm)
- mtvec  in  32  trap vector
- mepc  in  32  mret return address
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  fetch address
- imem_rsp_valid  in  1  read data valid (exactly one per accepted request, ≥1 cycle later)
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts
- if_instr  out  32  instruction word
- if_pc  out  32  address of if_instr
- misalign_trap  out  1  one-cycle pulse: redirect target misaligned
- misalign_addr  out  32  offending target, held until next trap
- pc  out  32  next address to be requested

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VEC, state=S_RESET.
  - imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0, misalign_trap=0, misalign_addr=0, imem_addr=RESET_VEC.
  - Reset mid-transaction abandons the outstanding fetch; memory is reset in the same domain.
- States:
  - S_RESET: one idle cycle after release, then S_REQ.
  - S_REQ: imem_req_valid=1, imem_addr=pc. On req_ready: issued_pc<=pc, pc<=pc+4 (mod 2^32, wraps FFFF_FFFC->0), go S_WAIT.
  - S_WAIT: on rsp_valid: if_instr<=data, if_pc<=issued_pc, if_valid<=1, go S_HOLD.
  - S_HOLD: if_valid=1. On if_ready: if_valid<=0, go S_REQ. The next request is issued the cycle after acceptance, giving 1 instr / 3 cycles with zero-wait memory; back-to-back overlap is not required.
  - S_KILL: a fetch is outstanding but dead. On rsp_valid, discard the data and go S_REQ.
- Redirect (ex_valid=1 and ex_pc_sel in 1..5), target:
  - sel=1: jalr_addr with bit0 forced 0.
  - sel=2: branch_addr.
  - sel=3: jal_addr.
  - sel=4: mtvec.
  - sel=5: mepc.
- Alignment check, applied to sel 1-3 only:
  - If target[1:0]!=0: pc<=mtvec, misalign_trap=1 for one cycle, misalign_addr<=target.
  - Otherwise pc<=target.
- Redirect per state (redirect has priority over all other state actions):
  - S_REQ: if req_ready is high in the same cycle, the request is considered issued to a dead address, so go S_KILL; otherwise stay S_REQ with the new pc.
  - S_WAIT: rsp_valid same cycle -> drop data, go S_REQ; else go S_KILL.
  - S_HOLD: drop the held instruction (if_valid<=0 even if if_ready=1 that cycle), go S_REQ.
  - S_KILL: update pc, stay S_KILL.
  - S_RESET: update pc.
- ex_valid with sel 0/6/7 is a no-op.
- imem_req_valid, once asserted, stays high with a stable imem_addr until accepted, unless a redirect occurs.
- All outputs are registered except imem_addr=pc and imem_req_valid=(state==S_REQ).

Decomposition:
- Shared package otter_pkg: PC_SEL_* encodings (3-bit localparams) and fetch state encoding.
- One sub-module: otter_pc_target_mux (combinational target select + jalr bit0 clear + misalign detect). The FSM and registers stay in the top.

Test Plan:
- Reset release, RESET_VEC=0, zero-wait memory, if_ready=1 -> requests at 0x0,0x4,0x8; if_pc sequence 0,4,8 matches data.
- jal redirect (jal_addr=0x100) while in S_WAIT, rsp arrives 2 cycles later -> that response discarded, next request addr 0x100, if_pc=0x100.
- jalr_addr=0x203 -> target 0x202 misaligned -> misalign_trap pulse, misalign_addr=0x202, next request at mtvec=0x80.
- if_ready=0 for 5 cycles with instruction held -> if_valid/if_instr/if_pc stable, no new imem request; then mret redirect (mepc=0x40) -> held word dropped, next request 0x40.
- pc=0xFFFF_FFFC request accepted -> pc wraps to 0x0000_0000.
- rst_n asserted while in S_KILL -> outputs at reset values immediately (async), restart at RESET_VEC.
